// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: key conditioning, start/stop/lap FSM and tick prescaler
// driving an external BCD counter chain and seven-segment display stage.

// Per-key conditioning: two-flop synchronizer, stability-window debounce,
// press pulse on a debounced 1->0 edge. The pulse is suppressed until the key
// has been seen released for a full window after reset. This stops a key held
// through reset from producing a press when reset is released.
module stopwatch_ctrl_key #(
    parameter int unsigned DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset_,
    input  logic key_,
    output logic press
);

    localparam int unsigned CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic          level;
    logic [CW-1:0] db_cnt;
    logic          armed;
    logic [CW-1:0] arm_cnt;
    logic [1:0]    fill;
    logic          fill_done;

    assign fill_done = (fill == 2'd2);

    // Two-flop synchronizer, released (1) out of reset
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
        end else begin
            sync_a <= key_;
            sync_b <= sync_a;
        end
    end

    // Marks when the synchronizer holds real key samples instead of reset values
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            fill <= '0;
        end else if (!fill_done) begin
            fill <= fill + 2'd1;
        end
    end

    // Debounced level follows the synchronized key after DB_CYCLES disagreeing cycles
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            level  <= 1'b1;
            db_cnt <= '0;
            press  <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync_b != level) begin
                if (db_cnt == DB_LAST) begin
                    level  <= sync_b;
                    db_cnt <= '0;
                    press  <= ~sync_b & armed;
                end else begin
                    db_cnt <= db_cnt + CW'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    // Arms press events once the key has been stably released after reset
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            armed   <= 1'b0;
            arm_cnt <= '0;
        end else if (!armed) begin
            if (fill_done && sync_b) begin
                if (arm_cnt == DB_LAST) begin
                    armed <= 1'b1;
                end else begin
                    arm_cnt <= arm_cnt + CW'(1);
                end
            end else begin
                arm_cnt <= '0;
            end
        end
    end

endmodule

module stopwatch_ctrl #(
    parameter int unsigned CLK_HZ    = 50000000,
    parameter int unsigned TICK_HZ   = 1000,
    parameter int unsigned DB_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset_,
    input  logic       key_ss_,
    input  logic       key_lap_,
    output logic       tick,
    output logic       clear_,
    output logic       freeze,
    output logic [1:0] state
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        LAP   = 2'b11
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic          ss_press;
    logic          lap_press;
    logic          lap_only;
    logic          clear_d;
    logic          clear_q;
    logic          freeze_q;
    logic          running;
    logic          running_d;
    logic [PW-1:0] pre;

    stopwatch_ctrl_key #(.DB_CYCLES(DB_CYCLES)) u_key_ss (
        .clk    (clk),
        .reset_ (reset_),
        .key_   (key_ss_),
        .press  (ss_press)
    );

    stopwatch_ctrl_key #(.DB_CYCLES(DB_CYCLES)) u_key_lap (
        .clk    (clk),
        .reset_ (reset_),
        .key_   (key_lap_),
        .press  (lap_press)
    );

    // Start/stop wins a same-cycle collision; the lap press is dropped
    assign lap_only  = lap_press & ~ss_press;
    assign running   = (state_q == RUN) || (state_q == LAP);
    assign running_d = (state_d == RUN) || (state_d == LAP);

    // Next-state and clear request from the current state and key events
    always_comb begin
        state_d = state_q;
        clear_d = 1'b1;
        case (state_q)
            IDLE: begin
                if (ss_press) begin
                    state_d = RUN;
                end else if (lap_only) begin
                    clear_d = 1'b0;
                end
            end
            RUN: begin
                if (ss_press) begin
                    state_d = PAUSE;
                end else if (lap_only) begin
                    state_d = LAP;
                end
            end
            PAUSE: begin
                if (ss_press) begin
                    state_d = RUN;
                end else if (lap_only) begin
                    state_d = IDLE;
                    clear_d = 1'b0;
                end
            end
            LAP: begin
                if (ss_press) begin
                    state_d = PAUSE;
                end else if (lap_only) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with clear and freeze registered alongside it
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q  <= IDLE;
            clear_q  <= 1'b1;
            freeze_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            clear_q  <= clear_d;
            freeze_q <= (state_d == LAP);
        end
    end

    // Prescaler advances only while staying in RUN/LAP, so it reads 0 whenever stopped
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            pre <= '0;
        end else if (running && running_d) begin
            pre <= (pre == PRE_LAST) ? '0 : pre + PW'(1);
        end else begin
            pre <= '0;
        end
    end

    // A start/stop press always leaves RUN/LAP, so that cycle never ticks
    assign tick   = running && (pre == PRE_LAST) && !ss_press;
    assign clear_ = clear_q;
    assign freeze = freeze_q;
    assign state  = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus random key activity,
// checked every cycle against a behavioural model of the key/FSM/tick rules.
module tb_stopwatch_ctrl;

    localparam int unsigned DIV = 10;
    localparam int unsigned DB  = 4;

    logic       clk = 1'b0;
    logic       reset_;
    logic       key_ss_;
    logic       key_lap_;
    logic       tick;
    logic       clear_;
    logic       freeze;
    logic [1:0] state;

    int checks = 0;
    int passed = 0;

    // Model state: spec state codes, running-cycle count, per-key debounce view
    int         m_st;
    int         m_phase;
    logic       m_clear;
    logic [1:0] m_ev;
    logic [1:0] m_db;
    logic [1:0] m_armed;
    int         m_dis[2];
    int         m_rel[2];
    logic [1:0] m_hist[$];

    // Observation bookkeeping for directed checks
    int         cyc = 0;
    int         tick_at[$];
    int         n_clear = 0;
    int         n_trans = 0;
    logic [1:0] prev_state = 2'b00;

    stopwatch_ctrl #(
        .CLK_HZ    (100),
        .TICK_HZ   (10),
        .DB_CYCLES (DB)
    ) dut (
        .clk      (clk),
        .reset_   (reset_),
        .key_ss_  (key_ss_),
        .key_lap_ (key_lap_),
        .tick     (tick),
        .clear_   (clear_),
        .freeze   (freeze),
        .state    (state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s @cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    endtask

    task automatic model_reset();
        m_st    = 0;
        m_phase = 0;
        m_clear = 1'b1;
        m_ev    = 2'b00;
        m_db    = 2'b11;
        m_armed = 2'b00;
        m_dis   = '{0, 0};
        m_rel   = '{0, 0};
        m_hist.delete();
    endtask

    // One clock edge of the reference behaviour; raw = {lap, ss} key levels at the edge
    task automatic model_edge(input logic [1:0] raw);
        logic       ss;
        logic       lp;
        int         ns;
        logic       run_old;
        logic       run_new;
        logic [1:0] seen;
        logic       valid;
        logic [1:0] new_ev;
        ss = m_ev[0];
        lp = m_ev[1] && !m_ev[0];
        ns = m_st;
        m_clear = 1'b1;
        case (m_st)
            0: if (ss) ns = 1; else if (lp) m_clear = 1'b0;
            1: if (ss) ns = 2; else if (lp) ns = 3;
            2: if (ss) ns = 1; else if (lp) begin ns = 0; m_clear = 1'b0; end
            default: if (ss) ns = 2; else if (lp) ns = 1;
        endcase
        run_old = (m_st == 1) || (m_st == 3);
        run_new = (ns == 1) || (ns == 3);
        m_phase = (run_old && run_new) ? m_phase + 1 : 0;
        m_st = ns;

        // Synchronized view is the key level from two edges back
        m_hist.push_back(raw);
        if (m_hist.size() > 3) void'(m_hist.pop_front());
        valid = (m_hist.size() == 3);
        seen  = valid ? m_hist[0] : 2'b11;
        new_ev = 2'b00;
        for (int k = 0; k < 2; k++) begin
            if (seen[k] != m_db[k]) begin
                m_dis[k]++;
                if (m_dis[k] == DB) begin
                    m_db[k]  = seen[k];
                    m_dis[k] = 0;
                    if (!seen[k] && m_armed[k]) new_ev[k] = 1'b1;
                end
            end else begin
                m_dis[k] = 0;
            end
            if (!m_armed[k]) begin
                if (valid && seen[k]) begin
                    m_rel[k]++;
                    if (m_rel[k] == DB) m_armed[k] = 1'b1;
                end else begin
                    m_rel[k] = 0;
                end
            end
        end
        m_ev = new_ev;
    endtask

    task automatic step();
        logic [1:0] raw;
        logic       tick_exp;
        @(posedge clk);
        raw = {key_lap_, key_ss_};
        if (!reset_) model_reset();
        else model_edge(raw);
        @(negedge clk);
        cyc++;
        tick_exp = ((m_st == 1) || (m_st == 3)) && ((m_phase % DIV) == DIV - 1) && !m_ev[0];
        check("state", {30'b0, state}, m_st);
        check("tick", {31'b0, tick}, {31'b0, tick_exp});
        check("clear_", {31'b0, clear_}, {31'b0, m_clear});
        check("freeze", {31'b0, freeze}, (m_st == 3) ? 1 : 0);
        if (tick === 1'b1) tick_at.push_back(cyc);
        if (clear_ === 1'b0) n_clear++;
        if (state !== prev_state) n_trans++;
        prev_state = state;
    endtask

    task automatic drive(input logic [1:0] mask, input logic lv);
        if (mask[0]) key_ss_ = lv;
        if (mask[1]) key_lap_ = lv;
    endtask

    // Optional bounce (low/high every 'period' cycles), then a held press, release and gap
    task automatic press(input logic [1:0] mask, input int blen, input int period,
                         input int hold, input int gap);
        for (int i = 0; i < blen; i++) begin
            logic lv;
            lv = ((i / period) % 2) != 0;
            drive(mask, lv);
            step();
        end
        drive(mask, 1'b0);
        repeat (hold) step();
        drive(mask, 1'b1);
        repeat (gap) step();
    endtask

    task automatic reset_pulse(input int cycles);
        #2;
        reset_ = 1'b0;
        #1;
        model_reset();
        check("rst_state", {30'b0, state}, 0);
        check("rst_tick", {31'b0, tick}, 0);
        check("rst_clear_", {31'b0, clear_}, 1);
        check("rst_freeze", {31'b0, freeze}, 0);
        repeat (cycles) step();
        reset_ = 1'b1;
    endtask

    initial begin
        int first_run;
        int first_tick;
        int second_tick;

        reset_   = 1'b0;
        key_ss_  = 1'b1;
        key_lap_ = 1'b1;
        model_reset();
        repeat (3) step();
        reset_ = 1'b1;
        repeat (10) step();

        // Clean start press: latency, first tick and tick period
        first_run   = -1;
        first_tick  = -1;
        second_tick = -1;
        key_ss_ = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (state === 2'b01 && first_run < 0) first_run = i;
            if (tick === 1'b1) begin
                if (first_tick < 0) first_tick = i;
                else if (second_tick < 0) second_tick = i;
            end
            if (i == 10) key_ss_ = 1'b1;
        end
        check("ss_press_latency", first_run, 7);
        check("first_tick_run_cycle", first_tick - first_run + 1, DIV);
        check("tick_period", second_tick - first_tick, DIV);

        // Lap in and out of RUN keeps the tick cadence
        tick_at.delete();
        press(2'b10, 0, 1, 8, 25);
        check("lap_state", {30'b0, state}, 3);
        check("lap_freeze", {31'b0, freeze}, 1);
        press(2'b10, 0, 1, 8, 25);
        check("unlap_state", {30'b0, state}, 1);
        check("unlap_freeze", {31'b0, freeze}, 0);
        check("lap_tick_seen", (tick_at.size() >= 5) ? 1 : 0, 1);
        for (int i = 1; i < tick_at.size(); i++)
            check("lap_tick_period", tick_at[i] - tick_at[i-1], DIV);

        // Pause, then lap clears back to IDLE with a single clear_ pulse
        press(2'b01, 0, 1, 8, 15);
        check("pause_state", {30'b0, state}, 2);
        n_clear = 0;
        tick_at.delete();
        press(2'b10, 0, 1, 8, 25);
        check("clear_state", {30'b0, state}, 0);
        check("clear_pulses", n_clear, 1);
        check("no_tick_after_pause", tick_at.size(), 0);

        // Simultaneous keys in RUN: start/stop wins, no clear
        press(2'b01, 0, 1, 8, 12);
        check("run_again", {30'b0, state}, 1);
        n_clear = 0;
        press(2'b11, 0, 1, 8, 15);
        check("both_state", {30'b0, state}, 2);
        check("both_freeze", {31'b0, freeze}, 0);
        check("both_no_clear", n_clear, 0);

        // Bouncing start key from IDLE yields one transition
        press(2'b10, 0, 1, 8, 15);
        n_trans = 0;
        press(2'b01, 20, 2, 10, 20);
        check("bounce_transitions", n_trans, 1);
        check("bounce_state", {30'b0, state}, 1);

        // Reset during RUN with the start key held
        repeat (5) step();
        key_ss_ = 1'b0;
        repeat (2) step();
        reset_pulse(3);
        n_trans = 0;
        repeat (20) step();
        check("held_key_no_event", n_trans, 0);
        check("held_key_state", {30'b0, state}, 0);
        key_ss_ = 1'b1;
        repeat (12) step();
        press(2'b01, 0, 1, 8, 10);
        check("repress_state", {30'b0, state}, 1);

        // Random key activity against the model
        for (int n = 0; n < 40; n++) begin
            press(2'($urandom_range(1, 3)), $urandom_range(0, 10), $urandom_range(1, 3),
                  $urandom_range(3, 10), $urandom_range(2, 25));
            if ($urandom_range(0, 9) == 0) begin
                reset_pulse($urandom_range(1, 4));
                repeat (8) step();
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
